// File: rtl/inertial_and_filter.sv
// Inertial-delay filter on in1 & in2: a change must persist DELAY sampled cycles to reach out.
// Optional glitch counter enabled by defining INERTIAL_GLITCH_COUNT_EN.
module inertial_and_filter #(
    parameter int DELAY = 10,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in1,
    input  logic             in2,
    output logic             out,
    output logic             pending,
    output logic             glitch,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int             CW       = $clog2(DELAY + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DELAY - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          pending_q, pending_d;
    logic          glitch_q, glitch_d;
    logic          raw;

    assign raw = in1 & in2;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        glitch_d = 1'b0;
        if (DELAY == 1) begin
            out_d   = raw;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (raw != out_q) begin
                        state_d = PEND;
                        cnt_d   = CNT_ONE;
                    end
                end
                PEND: begin
                    if (raw == out_q) begin
                        // Input fell back before qualifying: swallow the change.
                        state_d  = IDLE;
                        cnt_d    = '0;
                        glitch_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        out_d   = raw;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        pending_d = (state_d == PEND);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            pending_q <= 1'b0;
            glitch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            pending_q <= pending_d;
            glitch_q  <= glitch_d;
        end
    end

    assign out     = out_q;
    assign pending = pending_q;
    assign glitch  = glitch_q;

`ifdef INERTIAL_GLITCH_COUNT_EN
    logic [CNT_W-1:0] gcnt_q, gcnt_d;

    // Saturates at all-ones rather than wrapping.
    always_comb begin
        gcnt_d = gcnt_q;
        if (glitch_d && (gcnt_q != '1)) begin
            gcnt_d = gcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt = gcnt_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_inertial_and_filter.sv
// Scoreboard bench for inertial_and_filter: DELAY=10 and DELAY=1 instances share stimulus.
// Expected glitch_cnt follows whether INERTIAL_GLITCH_COUNT_EN is defined in this build.
module tb_inertial_and_filter;

`ifdef INERTIAL_GLITCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic             in1;
    logic             in2;
    logic             out10, pending10, glitch10;
    logic [CNT_W-1:0] gcnt10;
    logic             out1, pending1, glitch1;
    logic [CNT_W-1:0] gcnt1;

    inertial_and_filter #(.DELAY(10), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .in1(in1), .in2(in2),
        .out(out10), .pending(pending10), .glitch(glitch10), .glitch_cnt(gcnt10)
    );

    inertial_and_filter #(.DELAY(1), .CNT_W(CNT_W)) dut1 (
        .clock(clock), .reset(reset), .in1(in1), .in2(in2),
        .out(out1), .pending(pending1), .glitch(glitch1), .glitch_cnt(gcnt1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic out;
        logic pending;
        logic glitch;
        int   gcnt;
        int   run;
    } mstate_t;

    typedef struct {
        logic o10, p10, g10;
        int   c10;
        logic o1, p1, g1;
        int   c1;
    } exp_t;

    exp_t    sb[$];
    mstate_t m10, m1;
    int      n_checks = 0;
    int      n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Behavioural model: count consecutive edges where raw differs from out.
    function automatic mstate_t model_step(input mstate_t s, input logic raw, input logic rst,
                                           input int delay);
        mstate_t n;
        n        = s;
        n.glitch = 1'b0;
        if (rst) begin
            n.out = 1'b0; n.pending = 1'b0; n.gcnt = 0; n.run = 0;
            return n;
        end
        if (delay == 1) begin
            n.out = raw;
            n.run = 0;
        end else if (raw != s.out) begin
            n.run = s.run + 1;
            if (n.run == delay) begin
                n.out = raw;
                n.run = 0;
            end
        end else begin
            if (s.run > 0) begin
                n.glitch = 1'b1;
                if (CNT_EN && n.gcnt < CNT_MAX) n.gcnt = n.gcnt + 1;
            end
            n.run = 0;
        end
        n.pending = (n.run != 0);
        return n;
    endfunction

    task automatic drive(input logic a, input logic b, input logic r);
        exp_t e;
        @(negedge clock);
        in1   = a;
        in2   = b;
        reset = r;
        m10   = model_step(m10, a & b, r, 10);
        m1    = model_step(m1, a & b, r, 1);
        e.o10 = m10.out; e.p10 = m10.pending; e.g10 = m10.glitch; e.c10 = m10.gcnt;
        e.o1  = m1.out;  e.p1  = m1.pending;  e.g1  = m1.glitch;  e.c1  = m1.gcnt;
        sb.push_back(e);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out10",     32'(out10),     32'(e.o10));
            check("pending10", 32'(pending10), 32'(e.p10));
            check("glitch10",  32'(glitch10),  32'(e.g10));
            check("gcnt10",    32'(gcnt10),    32'(e.c10));
            check("out1",      32'(out1),      32'(e.o1));
            check("pending1",  32'(pending1),  32'(e.p1));
            check("glitch1",   32'(glitch1),   32'(e.g1));
            check("gcnt1",     32'(gcnt1),     32'(e.c1));
        end
    end

    initial begin
        int pend_cycles, rise_idx, g_pulses, out_low, side_hits;
        logic raw_t;
        in1 = 1'b0; in2 = 1'b0; reset = 1'b1;
        m10 = '{default: 0};
        m1  = '{default: 0};

        drive(0, 0, 1);
        drive(0, 0, 1);

        // Steady high input: 9 pending cycles, out rises after 10th edge.
        pend_cycles = 0; rise_idx = -1; g_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0);
            if (pending10) pend_cycles++;
            if (out10 && rise_idx < 0) rise_idx = i;
            if (glitch10) g_pulses++;
        end
        check("rise_pending_cycles", 32'(pend_cycles), 32'd9);
        check("rise_edge_index",     32'(rise_idx),    32'd10);
        check("rise_no_glitch",      32'(g_pulses),    32'd0);

        // Five-cycle dropout is swallowed with one glitch pulse.
        g_pulses = 0; out_low = 0;
        for (int i = 0; i < 10; i++) begin
            drive((i < 5) ? 1'b0 : 1'b1, 1, 0);
            if (glitch10) g_pulses++;
            if (!out10) out_low++;
        end
        check("drop_glitch_pulses", 32'(g_pulses), 32'd1);
        check("drop_out_held",      32'(out_low),  32'd0);
        check("drop_gcnt",          32'(gcnt10),   CNT_EN ? 32'd1 : 32'd0);

        // 300 three-cycle pulses saturate the counter; out never moves.
        out_low = 0;
        for (int p = 0; p < 300; p++) begin
            for (int k = 0; k < 4; k++) begin
                drive((k < 3) ? 1'b0 : 1'b1, 1, 0);
                if (!out10) out_low++;
            end
        end
        drive(1, 1, 0);
        drive(1, 1, 0);
        check("sat_out_held", 32'(out_low), 32'd0);
        check("sat_gcnt",     32'(gcnt10),  CNT_EN ? 32'(CNT_MAX) : 32'd0);

        // Reset mid-qualification (cnt=6) discards the change.
        drive(0, 0, 1);
        drive(0, 0, 1);
        for (int i = 0; i < 6; i++) drive(1, 1, 0);
        check("rst_pend_before", 32'(pending10), 32'd1);
        drive(1, 1, 1);
        drive(1, 1, 0);
        check("rst_out",     32'(out10),     32'd0);
        check("rst_pending", 32'(pending10), 32'd0);
        check("rst_glitch",  32'(glitch10),  32'd0);
        check("rst_gcnt",    32'(gcnt10),    32'd0);
        for (int i = 0; i < 8; i++) drive(1, 1, 0);
        drive(1, 1, 0);
        check("rst_out_after9", 32'(out10), 32'd0);
        drive(1, 1, 0);
        check("rst_out_after10", 32'(out10), 32'd1);

        // Toggle raw every cycle: DELAY=1 instance tracks it one cycle later.
        side_hits = 0;
        raw_t = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(raw_t, 1, 0);
            if (i > 0 && out1 !== ~raw_t) side_hits++;
            if (pending1 || glitch1) side_hits++;
            raw_t = ~raw_t;
        end
        check("d1_follow", 32'(side_hits), 32'd0);

        drive(0, 0, 0);
        @(posedge clock);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inertial_and_filter.md
INERTIAL_AND_FILTER -- requirements
Module: inertial_and_filter

Interface
REQ-001 SHALL have parameter DELAY, default 10, meaning the number of consecutive sampled cycles a changed input must hold before it reaches out (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of glitch_cnt.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port in1, input, 1, the first AND operand.
REQ-006 SHALL have port in2, input, 1, the second AND operand.
REQ-007 SHALL have port out, output, 1, the filtered and delayed value of in1 & in2.
REQ-008 SHALL have port pending, output, 1, high while a change of raw is being qualified.
REQ-009 SHALL have port glitch, output, 1, a one-cycle pulse marking a swallowed change.
REQ-010 SHALL have port glitch_cnt, output, CNT_W, the saturating count of swallowed changes.

Function
REQ-011 SHALL define raw = in1 & in2, sampled at each rising edge of clock.
REQ-012 SHALL implement two states, IDLE (raw matches out) and PEND (raw differs from out and is being qualified), using an internal counter cnt wide enough to hold DELAY.
REQ-013 In IDLE with raw != out and DELAY > 1, SHALL move to PEND and set cnt = 1.
REQ-014 In PEND with raw != out and cnt == DELAY-1, SHALL load out <= raw, clear cnt and return to IDLE; with cnt < DELAY-1 it SHALL increment cnt and stay in PEND.
REQ-015 In PEND with raw == out, SHALL return to IDLE, clear cnt, assert glitch for exactly one cycle and increment glitch_cnt.
REQ-016 SHALL change out only on the DELAY-th consecutive rising edge at which raw differs from out; latency is DELAY-1 cycles after the first sampling edge.
REQ-017 When DELAY == 1, SHALL register out <= raw every cycle, never enter PEND and never assert glitch.
REQ-018 SHALL drive pending high exactly when the state is PEND.
REQ-019 SHALL never let out toggle more than once per qualified change; a pulse shorter than DELAY sampled cycles never appears on out.
REQ-020 SHALL hold glitch_cnt at all-ones once it saturates, with no wrap.
REQ-021 SHALL register all outputs; there is no combinational path from any input to any output.

Reset
REQ-022 On reset high at a rising edge, SHALL set out=0, pending=0, glitch=0, glitch_cnt=0, cnt=0 and the state to IDLE.
REQ-023 SHALL give reset priority over all activity: reset during PEND discards the pending change and produces no glitch pulse.
REQ-024 SHALL start qualification again from zero on the first edge after reset deasserts.

Configuration
REQ-025 SHALL support macro INERTIAL_GLITCH_COUNT_EN controlling the glitch counter.
REQ-026 With INERTIAL_GLITCH_COUNT_EN defined, SHALL implement glitch_cnt as specified in REQ-015 and REQ-020.
REQ-027 With INERTIAL_GLITCH_COUNT_EN undefined, SHALL drive glitch_cnt constant 0 with no counter logic, while glitch still pulses as specified.

Verification (DELAY=10, CNT_W=8, macro defined unless stated)
REQ-028 Reset, then in1=in2=1 held for 20 cycles -> pending=1 for 9 cycles; out rises on the 10th edge after the sampling edge; glitch stays 0.
REQ-029 With out=1, drop in1 for 5 cycles and then restore it -> out stays 1; glitch pulses once on the edge after in1 returns; glitch_cnt=1.
REQ-030 Apply 300 short pulses of 3 cycles each -> glitch_cnt saturates at 255 and stays there; out never changes.
REQ-031 Assert reset at cnt=6 in PEND -> the next cycle shows out=0, pending=0, glitch=0 and glitch_cnt=0; a change held for a further 10 cycles then propagates normally.
REQ-032 With DELAY=1, toggle raw every cycle -> out follows raw one cycle later; pending and glitch stay 0.
REQ-033 With the macro undefined, repeat REQ-029 -> glitch pulses once and glitch_cnt stays 0.
